// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - op codes, FSM states and sizing shared by the muldiv sequencer
package muldiv_pkg;

    typedef enum logic [2:0] {
        MULT  = 3'd0,
        MULTU = 3'd1,
        DIV   = 3'd2,
        DIVU  = 3'd3,
        MTHI  = 3'd4,
        MTLO  = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_e;

    localparam int WIDTH_DEF = 32;
    localparam int ITER_W    = $clog2(WIDTH_DEF);

    function automatic logic is_muldiv_op(input logic [2:0] op);
        return (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == DIV) || (op == DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == MULT) || (op == DIV);
    endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// rtl/muldiv_datapath.sv - shift-add multiply / restoring divide iteration registers
module muldiv_datapath
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_load,
    input  logic               i_step,
    input  logic               i_is_div,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic [2*WIDTH-1:0] o_prod,
    output logic [WIDTH-1:0]   o_quot,
    output logic [WIDTH-1:0]   o_rem
);

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right.
    // Divide: acc[WIDTH-1:0] holds dividend bits shifting out at the top and
    // quotient bits shifting in at the bottom.
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   opnd_q;
    logic [WIDTH-1:0]   rem_q;
    logic               div_q;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     shifted;
    logic               fits;
    logic [WIDTH-1:0]   diff;

    always_comb begin
        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : {WIDTH{1'b0}})};
        shifted = {rem_q, acc_q[WIDTH-1]};
        fits    = shifted >= {1'b0, opnd_q};
        // Only consumed when fits, so the dropped top bit is always zero.
        diff    = shifted[WIDTH-1:0] - opnd_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc_q  <= '0;
            opnd_q <= '0;
            rem_q  <= '0;
            div_q  <= 1'b0;
        end else if (i_load) begin
            acc_q  <= {{WIDTH{1'b0}}, (i_is_div ? i_a : i_b)};
            opnd_q <= i_is_div ? i_b : i_a;
            rem_q  <= '0;
            div_q  <= i_is_div;
        end else if (i_step) begin
            if (div_q) begin
                rem_q              <= fits ? diff : shifted[WIDTH-1:0];
                acc_q[WIDTH-1:0]   <= {acc_q[WIDTH-2:0], fits};
            end else begin
                acc_q <= {mul_sum, acc_q[WIDTH-1:1]};
            end
        end
    end

    assign o_prod = acc_q;
    assign o_quot = acc_q[WIDTH-1:0];
    assign o_rem  = rem_q;

endmodule

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - HI/LO owner and iterative multiply/divide sequencer
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_op1,
    input  logic [WIDTH-1:0] i_op2,
    input  logic             i_flush,
    output logic             o_busy,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               is_div_q, div0_q, neg_lo_q, neg_hi_q;
    logic [WIDTH-1:0]   hi_q, lo_q;

    logic               accept, load, op_div, div0, s1, s2;
    logic [WIDTH-1:0]   a_in, b_in;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quot, rem, hi_new, lo_new;

    always_comb begin
        accept = (state_q == IDLE) && i_start && !i_flush;
        load   = accept && is_muldiv_op(i_op);
        op_div = is_div_op(i_op);
        div0   = op_div && (i_op2 == '0);
        s1     = is_signed_op(i_op) && i_op1[WIDTH-1];
        s2     = is_signed_op(i_op) && i_op2[WIDTH-1];
        // Divide-by-zero keeps the raw dividend so it can land in HI unmodified.
        a_in   = (s1 && !div0) ? -i_op1 : i_op1;
        b_in   = s2 ? -i_op2 : i_op2;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (load) state_d = div0 ? FIX : CALC;
            CALC:    if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (i_flush) state_d = IDLE;
    end

    muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_load   (load),
        .i_step   (state_q == CALC),
        .i_is_div (op_div),
        .i_a      (a_in),
        .i_b      (b_in),
        .o_prod   (prod),
        .o_quot   (quot),
        .o_rem    (rem)
    );

    always_comb begin
        // The product is negated as one 2W-bit value so the borrow crosses HI/LO.
        prod_fix = neg_lo_q ? -prod : prod;
        if (div0_q) begin
            hi_new = quot;
            lo_new = '1;
        end else if (is_div_q) begin
            hi_new = neg_hi_q ? -rem : rem;
            lo_new = neg_lo_q ? -quot : quot;
        end else begin
            hi_new = prod_fix[2*WIDTH-1:WIDTH];
            lo_new = prod_fix[WIDTH-1:0];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            div0_q   <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            if (load) begin
                cnt_q    <= '0;
                is_div_q <= op_div;
                div0_q   <= div0;
                neg_lo_q <= !div0 && (s1 ^ s2);
                neg_hi_q <= !div0 && (op_div ? s1 : (s1 ^ s2));
            end else if (state_q == CALC) begin
                cnt_q <= cnt_q + 1'b1;
            end

            if (state_q == FIX && !i_flush) begin
                hi_q <= hi_new;
                lo_q <= lo_new;
            end else if (accept && i_op == MTHI) begin
                hi_q <= i_op1;
            end else if (accept && i_op == MTLO) begin
                lo_q <= i_op1;
            end
        end
    end

    assign o_busy = (state_q != IDLE);
    assign o_hi   = hi_q;
    assign o_lo   = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - scoreboard bench for the muldiv sequencer
module tb_muldiv_ctrl;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic         i_clk = 1'b0;
    logic         i_rst_n = 1'b0;
    logic         i_start = 1'b0;
    logic         i_flush = 1'b0;
    logic [2:0]   i_op = 3'd0;
    logic [W-1:0] i_op1 = '0;
    logic [W-1:0] i_op2 = '0;
    logic         o_busy;
    logic [W-1:0] o_hi, o_lo;

    muldiv_ctrl #(.WIDTH(W)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_start (i_start),
        .i_op    (i_op),
        .i_op1   (i_op1),
        .i_op2   (i_op2),
        .i_flush (i_flush),
        .o_busy  (o_busy),
        .o_hi    (o_hi),
        .o_lo    (o_lo)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          busy;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        i_op    = op;
        i_op1   = a;
        i_op2   = b;
        i_start = 1'b1;
        step(1);
        i_start = 1'b0;
    endtask

    task automatic push_exp(input logic [31:0] hi, input logic [31:0] lo, input int busy);
        exp_t e;
        e.hi = hi;
        e.lo = lo;
        e.busy = busy;
        sb.push_back(e);
    endtask

    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sbv, q, r;
        logic [63:0] u;
        sa  = $signed({{32{a[31]}}, a});
        sbv = $signed({{32{b[31]}}, b});
        case (op)
            MULT:  begin u = sa * sbv; return u; end
            MULTU: return {32'd0, a} * {32'd0, b};
            DIV: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                q = sa / sbv;
                r = sa % sbv;
                return {r[31:0], q[31:0]};
            end
            DIVU: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: return 64'd0;
        endcase
    endfunction

    task automatic push_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] r;
        r = model(op, a, b);
        push_exp(r[63:32], r[31:0], ((op == DIV || op == DIVU) && b == 0) ? 1 : 33);
    endtask

    // Counts busy cycles from the cycle after the accepting edge, then pops and compares.
    task automatic finish_op(input string tag);
        int   n;
        exp_t e;
        n = 0;
        while (o_busy === 1'b1 && n < 200) begin
            step(1);
            n++;
        end
        check({tag, "_busy_drop"}, {31'd0, o_busy}, 32'd0);
        e = sb.pop_front();
        check({tag, "_busy_cycles"}, n, e.busy);
        check({tag, "_hi"}, o_hi, e.hi);
        check({tag, "_lo"}, o_lo, e.lo);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;

        i_rst_n = 1'b0;
        step(2);
        check("reset_busy", {31'd0, o_busy}, 32'd0);
        check("reset_hi", o_hi, 32'd0);
        check("reset_lo", o_lo, 32'd0);
        i_rst_n = 1'b1;
        step(1);

        push_exp(32'hFFFF_FFFE, 32'h0000_0001, 33);
        issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        finish_op("multu_max");

        push_exp(32'hFFFF_FFFF, 32'hFFFF_FFEB, 33);
        issue(MULT, 32'hFFFF_FFFD, 32'd7);
        finish_op("mult_neg3_7");

        push_exp(32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
        issue(DIV, 32'hFFFF_FFF9, 32'd2);
        finish_op("div_neg7_2");

        push_exp(32'd1, 32'd3, 33);
        issue(DIVU, 32'd7, 32'd2);
        finish_op("divu_7_2_b2b");

        push_exp(32'd0, 32'h8000_0000, 33);
        issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        finish_op("div_min_neg1");

        for (int k = 0; k < 4; k++) begin
            rop = 3'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            push_model(rop, ra, rb);
            issue(rop, ra, rb);
            finish_op($sformatf("rand%0d_op%0d", k, rop));
        end

        push_exp(32'h0000_1234, 32'hFFFF_FFFF, 1);
        issue(DIVU, 32'h0000_1234, 32'd0);
        finish_op("divu_by_zero");

        push_exp(32'hFFFF_FFF9, 32'hFFFF_FFFF, 1);
        issue(DIV, 32'hFFFF_FFF9, 32'd0);
        finish_op("div_neg_by_zero");

        issue(MTHI, 32'h1234_5678, 32'd0);
        check("mthi_busy", {31'd0, o_busy}, 32'd0);
        check("mthi_hi", o_hi, 32'h1234_5678);

        issue(MULTU, 32'd5, 32'd6);
        step(2);
        i_op    = MTLO;
        i_op1   = 32'hDEAD_BEEF;
        i_start = 1'b1;
        step(1);
        i_start = 1'b0;
        step(6);
        check("flush_pre_busy", {31'd0, o_busy}, 32'd1);
        i_flush = 1'b1;
        step(1);
        i_flush = 1'b0;
        check("flush_busy", {31'd0, o_busy}, 32'd0);
        check("flush_hi", o_hi, 32'h1234_5678);
        check("flush_lo", o_lo, 32'hFFFF_FFFF);
        step(40);
        check("flush_late_hi", o_hi, 32'h1234_5678);
        check("flush_late_lo", o_lo, 32'hFFFF_FFFF);

        i_op    = MTHI;
        i_op1   = 32'h0000_1111;
        i_start = 1'b1;
        i_flush = 1'b1;
        step(1);
        i_op    = MULTU;
        step(1);
        i_start = 1'b0;
        i_flush = 1'b0;
        check("flush_start_hi", o_hi, 32'h1234_5678);
        check("flush_start_busy", {31'd0, o_busy}, 32'd0);

        issue(MULTU, 32'd3, 32'd4);
        step(5);
        check("rst_pre_busy", {31'd0, o_busy}, 32'd1);
        #3;
        i_rst_n = 1'b0;
        #1;
        check("rst_async_busy", {31'd0, o_busy}, 32'd0);
        check("rst_async_hi", o_hi, 32'd0);
        check("rst_async_lo", o_lo, 32'd0);
        #2;
        i_rst_n = 1'b1;
        step(1);
        check("rst_release_busy", {31'd0, o_busy}, 32'd0);

        issue(MTLO, 32'hA5A5_A5A5, 32'd0);
        check("mtlo_lo", o_lo, 32'hA5A5_A5A5);
        check("mtlo_hi", o_hi, 32'd0);
        check("sb_empty", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
